audio_adc_i2s_rx: RTL and testbench

// - Capture-side audio interface: deserialises the codec's I2S ADC stream (AUD_ADCDAT/AUD_ADCLRCK/AUD_BCLK,

---
 rtl/audio_adc_i2s_rx.sv | 216 +++++++++++++++++++++
 tb/tb_audio_adc_i2s_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_i2s_rx.sv
// audio_adc_i2s_rx: I2S ADC capture. Deserialises the codec's serial ADC stream
// (the codec is bit-clock master) into left/right sample pairs in the clk_50
// domain and presents each pair through a valid/ready handshake.
//
// Ports:
//   clk_50       system clock
//   reset        asynchronous, active-low
//   aud_bclk     codec bit clock (asynchronous, <= clk_50/4)
//   aud_adclrck  codec word clock: low = left slot, high = right slot
//   aud_adcdat   codec serial data, MSB first, one-bit I2S delay after each lrck edge
//   out_left     left sample of the published pair
//   out_right    right sample of the published pair
//   out_valid    pair held on out_left/out_right
//   out_ready    consumer accepts the pair when out_valid && out_ready
//   overrun      1-cycle pulse: an unaccepted pair was overwritten
//   frame_err    1-cycle pulse: a slot ended before DATA_W bits arrived
//   overrun_cnt  (only when ADC_OVERRUN_CNT_EN is defined) saturating overrun count,
//                cleared when a pair is accepted
//
// Optional feature macro: ADC_OVERRUN_CNT_EN

module audio_adc_i2s_rx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
`ifdef ADC_OVERRUN_CNT_EN
  ,
  output logic [15:0]       overrun_cnt
`endif
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

  // Identical chains keep bclk, lrck and data mutually aligned.
  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], aud_bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], aud_adclrck};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], aud_adcdat};
    end
  end

  logic bclk_s, lrck_s, dat_s;
  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic              bclk_prev_q;
  logic              lrck_prev_q, lrck_prev_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_next;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              left_ok_q, left_ok_d;
  logic              pub_q, pub_d;
  logic [DATA_W-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              bit_evt, boundary, data_evt, word_done, short_slot, accept;

  always_comb begin
    bit_evt    = bclk_s & ~bclk_prev_q;
    boundary   = bit_evt & (lrck_s != lrck_prev_q);
    // Counter saturates at DATA_W so trailing slot bits are ignored.
    data_evt   = bit_evt & ~boundary & (bit_cnt_q != CntFull);
    word_done  = data_evt & (bit_cnt_q == CntLast);
    short_slot = boundary & (bit_cnt_q != CntFull);
    shift_next = {shift_q[DATA_W-2:0], dat_s};
    accept     = out_valid_q & out_ready;

    state_d     = state_q;
    lrck_prev_d = lrck_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    pub_d       = 1'b0;
    frame_err_d = 1'b0;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;

    if (bit_evt) lrck_prev_d = lrck_s;

    // The boundary bit is the I2S delay slot and carries no data.
    if (boundary) begin
      bit_cnt_d = '0;
    end else if (data_evt) begin
      shift_d   = shift_next;
      bit_cnt_d = bit_cnt_q + CntW'(1);
    end

    case (state_q)
      StSync: begin
        if (boundary && !lrck_s) begin
          state_d   = StLeft;
          left_ok_d = 1'b0;
        end
      end
      StLeft: begin
        if (boundary) begin
          state_d = StRight;
          if (short_slot) begin
            frame_err_d = 1'b1;
            left_ok_d   = 1'b0;
          end
        end else if (word_done) begin
          left_hold_d = shift_next;
          left_ok_d   = 1'b1;
        end
      end
      StRight: begin
        if (boundary) begin
          state_d     = StLeft;
          left_ok_d   = 1'b0;
          frame_err_d = short_slot;
        end else if (word_done && left_ok_q) begin
          pub_d = 1'b1;
        end
      end
      default: state_d = StSync;
    endcase

    // A publish landing with an acceptance replaces the consumed pair, no overrun.
    if (pub_q) begin
      out_left_d  = left_hold_q;
      out_right_d = shift_q;
      out_valid_d = 1'b1;
      overrun_d   = out_valid_q & ~out_ready;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StSync;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      pub_q       <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_prev_q <= bclk_s;
      lrck_prev_q <= lrck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      pub_q       <= pub_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

`ifdef ADC_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (accept && (ovr_cnt_q != 16'h0000)) begin
      ovr_cnt_d = 16'h0000;
    end else if (overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) ovr_cnt_q <= 16'h0000;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_audio_adc_i2s_rx.sv
// Bench for audio_adc_i2s_rx: drives I2S frames (directed and $urandom) and compares
// every output each clk_50 cycle against a frame-level reference model.

module tb_audio_adc_i2s_rx;

  localparam int unsigned DW = 16;
  localparam int unsigned SS = 2;

  logic          clk_50 = 1'b0;
  logic          reset = 1'b1;
  logic          aud_bclk = 1'b0, aud_adclrck = 1'b0, aud_adcdat = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_left, out_right;
  logic          out_valid, overrun, frame_err;
`ifdef ADC_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #10 clk_50 = ~clk_50;

  audio_adc_i2s_rx #(
    .DATA_W     (DW),
    .SYNC_STAGES(SS)
  ) u_dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .aud_bclk   (aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_adcdat (aud_adcdat),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
`ifdef ADC_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected publish / frame-error events are scheduled by the
  // stimulus at the cycle the spec fixes relative to the pin-level bclk rise.
  typedef struct {
    int            at;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pub_t;

  int            cyc = 0;
  pub_t          pub_qu[$];
  int            ferr_qu[$];
  logic          m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [DW-1:0] m_left = '0, m_right = '0;
  logic [15:0]   m_cnt = '0;

  always @(posedge clk_50 or negedge reset) begin : model
    pub_t        p;
    int          now;
    logic        nv, acc, pub_now;
    logic [15:0] nc;
    if (!reset) begin
      m_valid <= 1'b0;
      m_left  <= '0;
      m_right <= '0;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
      m_cnt   <= '0;
      pub_qu.delete();
      ferr_qu.delete();
    end else begin
      now = cyc + 1;
      cyc <= now;
      acc = m_valid && out_ready;
      nv = m_valid;
      pub_now = 1'b0;
      m_ovr  <= 1'b0;
      m_ferr <= 1'b0;
      if (ferr_qu.size() != 0 && ferr_qu[0] == now) begin
        void'(ferr_qu.pop_front());
        m_ferr <= 1'b1;
      end
      if (pub_qu.size() != 0 && pub_qu[0].at == now) begin
        p = pub_qu.pop_front();
        pub_now = 1'b1;
        m_ovr   <= m_valid && !out_ready;
        m_left  <= p.l;
        m_right <= p.r;
        nv = 1'b1;
      end else if (acc) begin
        nv = 1'b0;
      end
      m_valid <= nv;
      nc = m_cnt;
      if (acc && m_cnt != 16'h0) nc = 16'h0;
      else if (pub_now && m_valid && !out_ready && m_cnt != 16'hFFFF) nc = m_cnt + 16'h1;
      m_cnt <= nc;
    end
  end

  always @(negedge clk_50) begin
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("out_left", 32'(out_left), 32'(m_left));
    check_eq("out_right", 32'(out_right), 32'(m_right));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef ADC_OVERRUN_CNT_EN
    check_eq("overrun_cnt", 32'(overrun_cnt), 32'(m_cnt));
`endif
  end

  // out_ready policy: 0 = always ready, 1 = never ready, 2 = random.
  int rmode = 0;
  always @(posedge clk_50) begin
    #5;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom);
    endcase
  end

  bit prev_short = 1'b0;

  // Inputs change 5 time units after the rising clock edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50);
    #5;
  endtask

  task automatic send_bit(input logic lr, input logic d, input int hp, input bit pub_en,
                          input logic [DW-1:0] pl, input logic [DW-1:0] pr, input bit ferr_en);
    pub_t p;
    aud_bclk    = 1'b0;
    aud_adclrck = lr;
    aud_adcdat  = d;
    wait_cyc(hp);
    aud_bclk = 1'b1;
    if (pub_en) begin
      p.at = cyc + int'(SS) + 2;
      p.l  = pl;
      p.r  = pr;
      pub_qu.push_back(p);
    end
    if (ferr_en) ferr_qu.push_back(cyc + int'(SS) + 1);
    wait_cyc(hp);
  endtask

  // One slot: delay bit, then nbits data bits MSB first (a full slot pads to 'slot').
  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nbits, input int slot,
                           input int hp, input bit pub, input logic [DW-1:0] pl, input bit ferr);
    int   len;
    logic d;
    len = (nbits < int'(DW)) ? nbits + 1 : slot;
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= int'(DW)) d = w[int'(DW) - i];
      else d = 1'($urandom);
      send_bit(lr, d, hp, pub && (i == int'(DW)), pl, w, ferr && (i == 0));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lbits,
                            input int rbits, input int slot, input int hp);
    send_slot(1'b0, l, lbits, slot, hp, 1'b0, l, prev_short);
    prev_short = (lbits < int'(DW));
    send_slot(1'b1, r, rbits, slot, hp, (lbits >= int'(DW)), l, prev_short);
    prev_short = (rbits < int'(DW));
  endtask

  // Partial right slot after reset: must never produce a pair.
  task automatic preamble(input int hp);
    send_slot(1'b1, DW'($urandom), int'(DW), int'(DW) + 2, hp, 1'b0, '0, 1'b0);
    prev_short = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      aud_bclk    = 1'($urandom);
      aud_adclrck = 1'($urandom);
      aud_adcdat  = 1'($urandom);
      wait_cyc(1);
    end
    aud_bclk    = 1'b0;
    aud_adclrck = 1'b0;
    aud_adcdat  = 1'b0;
    prev_short  = 1'b0;
    reset = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    #1 reset = 1'b0;
    rmode = 2;
    wait_cyc(1);
    do_reset(20);
    preamble(8);

    // Basic frame: 3.125 MHz bclk, 32-bit slots, always ready.
    rmode = 0;
    send_frame(16'h8001, 16'h7FFE, DW, DW, 32, 8);
    wait_cyc(10);

    // Backpressure: A then B unaccepted, one overrun at B, then accept.
    rmode = 1;
    send_frame(16'h1111, 16'h2222, DW, DW, 32, 8);
    send_frame(16'h3333, 16'h4444, DW, DW, 32, 8);
    wait_cyc(10);
    check_eq("bp_left", 32'(out_left), 32'h3333);
    check_eq("bp_right", 32'(out_right), 32'h4444);
    check_eq("bp_valid", 32'(out_valid), 32'h1);
    rmode = 0;
    wait_cyc(5);

    // Four unaccepted frames: three overruns.
    rmode = 1;
    for (int i = 0; i < 4; i++) send_frame(DW'($urandom), DW'($urandom), DW, DW, 17, 3);
    wait_cyc(10);
`ifdef ADC_OVERRUN_CNT_EN
    check_eq("ovr_cnt_3", 32'(overrun_cnt), 32'h3);
`endif
    rmode = 0;
    wait_cyc(5);
`ifdef ADC_OVERRUN_CNT_EN
    check_eq("ovr_cnt_clr", 32'(overrun_cnt), 32'h0);
`endif

    // Short slots: 10-bit left suppresses the pair; short right flags on next boundary.
    send_frame(16'hA5A5, 16'h5A5A, 10, DW, 24, 4);
    send_frame(16'hC001, 16'h0FF0, DW, DW, 24, 4);
    send_frame(16'h1234, 16'h5678, DW, 7, 20, 3);
    send_frame(16'hFFFF, 16'h0000, DW, DW, 20, 3);
    wait_cyc(10);

    // Random frames with random backpressure.
    rmode = 2;
    for (int i = 0; i < 10; i++) begin
      int lb, rb;
      lb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, DW - 1)) : int'(DW);
      rb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, DW - 1)) : int'(DW);
      send_frame(DW'($urandom), DW'($urandom), lb, rb, int'($urandom_range(DW + 1, DW + 6)),
                 int'($urandom_range(2, 6)));
    end
    wait_cyc(10);

    // Reset during right bit 7: the broken frame yields nothing.
    rmode = 0;
    send_slot(1'b0, 16'hDEAD, DW, 20, 4, 1'b0, '0, prev_short);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'($urandom), 4, 1'b0, '0, '0, 1'b0);
    aud_bclk   = 1'b0;
    aud_adcdat = 1'($urandom);
    wait_cyc(2);
    do_reset(12);
    preamble(4);
    send_frame(16'h6B3C, 16'h91E7, DW, DW, 20, 4);
    wait_cyc(10);
    check_eq("post_rst_left", 32'(out_left), 32'h6B3C);
    check_eq("post_rst_right", 32'(out_right), 32'h91E7);

    wait_cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
